// File: rtl/display.sv
// Four-digit multiplexed seven-segment driver: shows a BCD score or a lane
// pattern, scanning one digit every SCAN_DIV clocks, plus mirrored status LEDs.
module display #(
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic [7:0]  score,
  input  logic [3:0]  pattern,
  input  logic        C,
  output logic [7:0]  SEG,
  output logic [3:0]  AN,
  output logic [7:0]  LED,
  output logic [15:0] test,
  output logic [11:0] test0
);

  logic [7:0] hun, ten, one;
  logic       tick;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] led_q, led_d;
  logic [3:0] nib;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 8'hC0;
      4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;
      4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;
      4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;
      4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;
      4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'hB6;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  always_comb begin
    hun   = score / 8'd100;
    ten   = (score / 8'd10) % 8'd10;
    one   = score % 8'd10;
    test0 = {hun[3:0], ten[3:0], one[3:0]};
    test  = 16'hFFFF;
    if (C) begin
      for (int i = 0; i < 4; i++) test[i*4 +: 4] = pattern[i] ? 4'hA : 4'hF;
    end else begin
      // leading-zero suppression; ones digit always visible
      test = {4'hF,
              (hun == 8'd0) ? 4'hF : hun[3:0],
              (hun == 8'd0 && ten == 8'd0) ? 4'hF : ten[3:0],
              one[3:0]};
    end
  end

  generate
    if (SCAN_DIV == 1) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int CW = $clog2(SCAN_DIV);
      logic [CW-1:0] cnt_q, cnt_d;
      assign tick  = (cnt_q == CW'(SCAN_DIV - 1));
      assign cnt_d = tick ? '0 : cnt_q + 1'b1;
      always_ff @(posedge clk or negedge res) begin
        if (!res) cnt_q <= '0;
        else      cnt_q <= cnt_d;
      end
    end
  endgenerate

  always_comb begin
    nib   = test[{idx_q, 2'b00} +: 4];
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    led_d = C ? {4'b0000, pattern} : score;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(nib);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      idx_q <= 2'd0;
      an_q  <= 4'hF;
      seg_q <= 8'hFF;
      led_q <= 8'h00;
    end else begin
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      led_q <= led_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign LED = led_q;

endmodule

// File: tb/tb_display.sv
// Directed bench for display (SCAN_DIV=1): combinational vector table plus
// scan, reset and mode-change sequences; outputs sampled on the falling edge.
module tb_display;

  logic        clk = 1'b0;
  logic        res;
  logic [7:0]  score;
  logic [3:0]  pattern;
  logic        C;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic [7:0]  LED;
  logic [15:0] test;
  logic [11:0] test0;

  int n_cmp = 0;
  int n_bad = 0;

  display #(.SCAN_DIV(1)) dut (
    .clk(clk), .res(res), .score(score), .pattern(pattern), .C(C),
    .SEG(SEG), .AN(AN), .LED(LED), .test(test), .test0(test0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [7:0]  sc;
    logic [3:0]  pat;
    logic [15:0] e_test;
    logic [11:0] e_test0;
    logic [7:0]  e_led;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    res = 1'b0;
    edge_n(2);
  endtask

  logic [3:0] an_seq[5];
  logic [7:0] seg_seq[5];

  initial begin
    res = 1'b0; score = 8'd128; pattern = 4'b0110; C = 1'b1;
    vecs[0] = '{1'b1, 8'd128, 4'b0110, 16'hFAAF, 12'h128, 8'h06};
    vecs[1] = '{1'b1, 8'd0,   4'b0000, 16'hFFFF, 12'h000, 8'h00};
    vecs[2] = '{1'b1, 8'd9,   4'b1111, 16'hAAAA, 12'h009, 8'h0F};
    vecs[3] = '{1'b1, 8'd200, 4'b1001, 16'hAFFA, 12'h200, 8'h09};
    vecs[4] = '{1'b0, 8'd0,   4'b1010, 16'hFFF0, 12'h000, 8'h00};
    vecs[5] = '{1'b0, 8'd7,   4'b1010, 16'hFFF7, 12'h007, 8'h07};
    vecs[6] = '{1'b0, 8'd10,  4'b0000, 16'hFF10, 12'h010, 8'h0A};
    vecs[7] = '{1'b0, 8'd255, 4'b0000, 16'hF255, 12'h255, 8'hFF};
    vecs[8] = '{1'b0, 8'd128, 4'b0000, 16'hF128, 12'h128, 8'h80};
    vecs[9] = '{1'b0, 8'd100, 4'b0001, 16'hF100, 12'h100, 8'h64};

    // held in reset with the clock running
    edge_n(3);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_an", AN, 4'hF);
    chk("rst_led", LED, 8'h00);
    chk("rst_test", test, 16'hFAAF);
    chk("rst_test0", test0, 12'h128);

    // combinational functions also valid during reset
    for (int i = 0; i < 10; i++) begin
      C = vecs[i].c; score = vecs[i].sc; pattern = vecs[i].pat;
      #1;
      chk($sformatf("rst_vec%0d_test", i), test, vecs[i].e_test);
      chk($sformatf("rst_vec%0d_test0", i), test0, vecs[i].e_test0);
    end

    // table after release, including the registered LED
    res = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      C = vecs[i].c; score = vecs[i].sc; pattern = vecs[i].pat;
      #1;
      chk($sformatf("vec%0d_test", i), test, vecs[i].e_test);
      chk($sformatf("vec%0d_test0", i), test0, vecs[i].e_test0);
      @(negedge clk);
      chk($sformatf("vec%0d_led", i), LED, vecs[i].e_led);
    end

    // pattern scan from reset
    do_reset;
    C = 1'b1; pattern = 4'b0110; score = 8'd128;
    res = 1'b1;
    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_seq = '{8'hFF, 8'hB6, 8'hB6, 8'hFF, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("pat_an%0d", i), AN, an_seq[i]);
      chk($sformatf("pat_seg%0d", i), SEG, seg_seq[i]);
    end
    chk("pat_led", LED, 8'h06);

    // score scan from reset
    do_reset;
    C = 1'b0; score = 8'd128;
    res = 1'b1;
    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_seq = '{8'h80, 8'hA4, 8'hF9, 8'hFF, 8'h80};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("sc_an%0d", i), AN, an_seq[i]);
      chk($sformatf("sc_seg%0d", i), SEG, seg_seq[i]);
    end
    chk("sc_led", LED, 8'h80);
    chk("sc_test", test, 16'hF128);

    // reset pulsed mid-scan while digit 2 is lit
    do_reset;
    res = 1'b1;
    edge_n(3);
    chk("mid_an_before", AN, 4'b1011);
    #2 res = 1'b0;
    #1;
    chk("mid_seg_async", SEG, 8'hFF);
    chk("mid_an_async", AN, 4'hF);
    chk("mid_led_async", LED, 8'h00);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    chk("mid_an_restart", AN, 4'b1110);
    chk("mid_seg_restart", SEG, 8'h80);

    // mode change mid-scan keeps the index
    do_reset;
    C = 1'b1; pattern = 4'b0110; score = 8'd128;
    res = 1'b1;
    @(negedge clk);
    chk("mode_an0", AN, 4'b1110);
    chk("mode_seg0", SEG, 8'hFF);
    C = 1'b0;
    @(negedge clk);
    chk("mode_an1", AN, 4'b1101);
    chk("mode_seg1", SEG, 8'hA4);
    chk("mode_led1", LED, 8'h80);
    @(negedge clk);
    chk("mode_an2", AN, 4'b1011);
    chk("mode_seg2", SEG, 8'hF9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
